ch0re_hazard_ctrl: RTL
======================

// Module: ch0re_hazard_ctrl
// PURPOSE
//  Pipeline hazard/sequencing controller for the 5-stage RV64I core. Keeps a shadow
//  scoreboard of in-flight destinations (EX, MEM, WB). From it, drives stall, flush and
//  forwarding selects so RAW hazards, load-use hazards and EX-resolved redirects execute
//  correctly. Sits beside the ID stage; outputs gate REG_PC, IFIDR and IDEXR and the EX ALU muxes.
// PARAMETERS
//  FWD_EN        1   1: forwarding active, stall only on load-use; 0: stall on any RAW in flight
//  RF_WB_BYPASS  1   1: regfile write-through (WB-stage writer is not a hazard); 0: WB counts
//  CNT_WIDTH     32  width of saturating performance counters
// PORTS
//  clk           in   1          clock
//  rst_n         in   1          asynchronous active-low reset
//  id_valid      in   1          valid instruction in ID this cycle
//  id_rs1        in   5          ID source 1 index
//  id_rs2        in   5          ID source 2 index
//  id_rs1_used   in   1          instruction reads rs1
//  id_rs2_used   in   1          instruction reads rs2
//  id_rd         in   5          ID destination index
//  id_wen        in   1          instruction writes rd
//  id_is_load    in   1          instruction is LSU_LOAD
//  ex_redirect   in   1          branch/jump taken resolved in EX this cycle
//  stall_o       out  1          hold REG_PC and IFIDR; load bubble into IDEXR
//  flush_ifid_o  out  1          zero IFIDR on next edge
//  flush_idex_o  out  1          zero IDEXR on next edge
//  fwd_rs1_sel_o out  2          EX operand-1 source: 00 regfile, 01 EXMEMR, 10 MEMWBR
//  fwd_rs2_sel_o out  2          EX operand-2 source, same encoding
//  stall_cnt_o   out  CNT_WIDTH  cycles with stall_o=1, saturating
//  flush_cnt_o   out  CNT_WIDTH  cycles with ex_redirect=1, saturating
// BEHAVIOUR
//  - rst_n=0 (async): scoreboard entries invalid, fwd selects 00, counters 0; combinational
//    outputs then 0 because all entries invalid.
//  - Scoreboard: sb_ex, sb_mem and sb_wb, each {valid, rd, wen, is_load}. Every edge:
//    sb_wb<=sb_mem, sb_mem<=sb_ex, sb_ex<=ID entry. When stall_o or ex_redirect,
//    sb_ex<=invalid (bubble).
//  - Match(src, e): src_used & src!=0 & e.valid & e.wen & e.rd==src.
//  - FWD_EN=0: stall_o = id_valid & any Match vs sb_ex, sb_mem, or (RF_WB_BYPASS=0) sb_wb.
//  - FWD_EN=1: stall_o = id_valid & Match(.,sb_ex) & sb_ex.is_load (load-use, one bubble).
//  - Combinational paths: stall and flush are same-cycle functions of ID inputs,
//    ex_redirect and the scoreboard. Zero latency.
//  - Forward selects are registered, so they align with the instruction when it reaches EX.
//    Not stalled and no redirect: sel<=01 if Match vs sb_ex, else 10 if Match vs sb_mem,
//    else 00. Youngest writer wins. FWD_EN=0: sel is always 00.
//  - Forward selects on a stall or redirect cycle: sel<=00, because a bubble enters EX.
//  - ex_redirect has priority over stall: flush_ifid_o=flush_idex_o=1, stall_o=0.
//  - Counters saturate at all-ones and never wrap. Stall and redirect never count on the same cycle.
//  - id_valid=0: no stall. The ID entry enters the scoreboard as invalid.
//  - Reset mid-stall: outputs drop immediately. The pipeline restarts with an empty scoreboard.
// STRUCTURE
//  - ch0re_pkg: typedef enum logic[1:0] fwd_sel_e {FWD_RF, FWD_EXMEM, FWD_MEMWB}.
//  - ch0re_pkg: typedef struct packed sb_entry_t {valid, rd[4:0], wen, is_load}.
//  - Sub-module ch0re_sat_cnt #(WIDTH) (clk, rst_n, inc, cnt), instanced twice.
//  - The remainder is one always_ff for the scoreboard and selects, plus one always_comb for the hazard logic.
// TESTING
//  1 FWD_EN=0: addi x5 then add x6,x5,x5 back-to-back -> stall_o=1 for 2 cycles
//    (RF_WB_BYPASS=1); stall_cnt_o=2.
//  2 FWD_EN=1, same pair -> no stall; fwd_rs1_sel_o=fwd_rs2_sel_o=01 the cycle the add is in EX.
//  3 FWD_EN=1: ld x7 then add x8,x7,x0 -> exactly 1 stall cycle; the add then sees
//    fwd_rs1_sel_o=10 and fwd_rs2_sel_o=00.
//  4 Writer rd=x0 followed by reader of x0 -> no stall, selects 00.
//  5 Hazard stall and ex_redirect in the same cycle -> stall_o=0, both flushes=1, flush_cnt_o+1.
//  6 Force stall_cnt_o to 32'hFFFFFFFF, keep stalling -> value holds; assert rst_n mid-stall
//    -> all outputs 0 immediately.

Source files
------------

// File: rtl/ch0re_pkg.sv
// Shared types for the ch0re pipeline hazard controller.
// Contents: forwarding-select encoding, scoreboard entry layout, source-match helper.
// No ports; imported by ch0re_hazard_ctrl and its sub-modules.
package ch0re_pkg;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wen;
      logic       is_load;
   } sb_entry_t;

   localparam sb_entry_t SB_EMPTY = '0;

   // True when an in-flight entry will write the register a source operand reads.
   // x0 is hard-wired zero, so it never carries a dependency.
   function automatic logic sb_match(input logic used, input logic [4:0] src,
                                     input sb_entry_t e);
      return used & (src != 5'd0) & e.valid & e.wen & (e.rd == src);
   endfunction

endpackage

// File: rtl/ch0re_sat_cnt.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones.
// Ports: clk, rst_n (async active-low, clears count), inc (count enable), cnt (value).
// One-cycle update latency; no backpressure.
module ch0re_sat_cnt #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ch0re_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV64I core, sitting beside ID.
// Inputs: ID operand/destination info, ex_redirect. Outputs: stall_o, flush_ifid_o,
// flush_idex_o (same-cycle), fwd_rs*_sel_o (registered, aligned to EX), saturating
// stall/flush counters. clk, rst_n asynchronous active-low.
module ch0re_hazard_ctrl
   import ch0re_pkg::*;
#(
   parameter bit FWD_EN       = 1'b1,
   parameter bit RF_WB_BYPASS = 1'b1,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 id_valid,
   input  logic [4:0]           id_rs1,
   input  logic [4:0]           id_rs2,
   input  logic                 id_rs1_used,
   input  logic                 id_rs2_used,
   input  logic [4:0]           id_rd,
   input  logic                 id_wen,
   input  logic                 id_is_load,
   input  logic                 ex_redirect,
   output logic                 stall_o,
   output logic                 flush_ifid_o,
   output logic                 flush_idex_o,
   output logic [1:0]           fwd_rs1_sel_o,
   output logic [1:0]           fwd_rs2_sel_o,
   output logic [CNT_WIDTH-1:0] stall_cnt_o,
   output logic [CNT_WIDTH-1:0] flush_cnt_o
);

   sb_entry_t sb_ex, sb_mem, sb_wb;
   fwd_sel_e  rs1_sel_q, rs2_sel_q;
   fwd_sel_e  rs1_sel_d, rs2_sel_d;

   logic m1_ex, m2_ex, m1_mem, m2_mem, m1_wb, m2_wb;
   logic hazard;
   logic bubble;

   always_comb begin
      m1_ex     = sb_match(id_rs1_used, id_rs1, sb_ex);
      m2_ex     = sb_match(id_rs2_used, id_rs2, sb_ex);
      m1_mem    = sb_match(id_rs1_used, id_rs1, sb_mem);
      m2_mem    = sb_match(id_rs2_used, id_rs2, sb_mem);
      m1_wb     = sb_match(id_rs1_used, id_rs1, sb_wb);
      m2_wb     = sb_match(id_rs2_used, id_rs2, sb_wb);
      hazard    = 1'b0;
      rs1_sel_d = FWD_RF;
      rs2_sel_d = FWD_RF;

      if (FWD_EN) begin
         // With forwarding only a load in EX is too late: its data exists after MEM.
         hazard = (m1_ex | m2_ex) & sb_ex.is_load;
      end else begin
         hazard = m1_ex | m2_ex | m1_mem | m2_mem
                | (~RF_WB_BYPASS & (m1_wb | m2_wb));
      end

      // Redirect wins: the ID instruction is being squashed, so stalling it is moot.
      stall_o      = id_valid & hazard & ~ex_redirect;
      flush_ifid_o = ex_redirect;
      flush_idex_o = ex_redirect;
      bubble       = stall_o | ex_redirect;

      // EX stage is checked first so the youngest writer's value is forwarded.
      if (FWD_EN && !bubble) begin
         if (m1_ex)       rs1_sel_d = FWD_EXMEM;
         else if (m1_mem) rs1_sel_d = FWD_MEMWB;
         if (m2_ex)       rs2_sel_d = FWD_EXMEM;
         else if (m2_mem) rs2_sel_d = FWD_MEMWB;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_ex     <= SB_EMPTY;
         sb_mem    <= SB_EMPTY;
         sb_wb     <= SB_EMPTY;
         rs1_sel_q <= FWD_RF;
         rs2_sel_q <= FWD_RF;
      end else begin
         sb_wb  <= sb_mem;
         sb_mem <= sb_ex;
         if (bubble) begin
            sb_ex <= SB_EMPTY;
         end else begin
            sb_ex <= '{valid: id_valid, rd: id_rd, wen: id_wen, is_load: id_is_load};
         end
         rs1_sel_q <= rs1_sel_d;
         rs2_sel_q <= rs2_sel_d;
      end
   end

   assign fwd_rs1_sel_o = rs1_sel_q;
   assign fwd_rs2_sel_o = rs2_sel_q;

   ch0re_sat_cnt #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_o),
      .cnt   (stall_cnt_o)
   );

   ch0re_sat_cnt #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ex_redirect),
      .cnt   (flush_cnt_o)
   );

endmodule
